// File: rtl/ifetch_buf_if.sv
// ifetch_buf_if: memory request/response and decode-side channels of ifetch_buf.
// master = fetch buffer side, slave = memory / decode side.
interface ifetch_buf_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid_o;
    logic [ADDR_W-1:0] req_addr_o;
    logic              req_ready_i;
    logic              rsp_valid_i;
    logic [DATA_W-1:0] rsp_data_i;
    logic              inst_valid_o;
    logic [DATA_W-1:0] inst_o;
    logic [ADDR_W-1:0] inst_addr_o;
    logic              inst_ready_i;

    modport master (
        output req_valid_o,
        output req_addr_o,
        input  req_ready_i,
        input  rsp_valid_i,
        input  rsp_data_i,
        output inst_valid_o,
        output inst_o,
        output inst_addr_o,
        input  inst_ready_i
    );

    modport slave (
        input  req_valid_o,
        input  req_addr_o,
        output req_ready_i,
        output rsp_valid_i,
        output rsp_data_i,
        input  inst_valid_o,
        input  inst_o,
        input  inst_addr_o,
        output inst_ready_i
    );
endinterface

// File: rtl/ifetch_buf.sv
// ifetch_buf: in-order instruction fetch front end with credit-based issue,
// jump flush and an address-tagged instruction FIFO for decode.
// Ports: clk, rst_n (async, active-low), pc_addr_i, jump_en_i, pc_hold_o,
//   bus (ifetch_buf_if.master: req_*, rsp_*, inst_*).
// Optional macro IFETCH_BYPASS_EN: an empty FIFO forwards a response
//   combinationally to the decode side in the response cycle.
module ifetch_buf #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int MAX_OS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] pc_addr_i,
    input  logic              jump_en_i,
    output logic              pc_hold_o,
    ifetch_buf_if.master      bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int QW = (MAX_OS > 1) ? $clog2(MAX_OS) : 1;
    localparam logic [QW:0]   OS_MAX  = (QW+1)'(MAX_OS);
    localparam logic [QW-1:0] AQ_LAST = QW'(MAX_OS - 1);

    // address queue: one entry per outstanding request
    logic [ADDR_W-1:0] aq_addr_q [MAX_OS];
    logic [QW-1:0]     aq_wr_q, aq_wr_d;
    logic [QW-1:0]     aq_rd_q, aq_rd_d;
    logic [QW:0]       os_cnt_q, os_cnt_d;
    logic [QW:0]       drop_cnt_q, drop_cnt_d;

    // instruction FIFO
    logic [ADDR_W-1:0] f_addr_q [DEPTH];
    logic [DATA_W-1:0] f_data_q [DEPTH];
    logic [PW-1:0]     f_wr_q, f_wr_d;
    logic [PW-1:0]     f_rd_q, f_rd_d;
    logic [PW:0]       f_cnt_q, f_cnt_d;

    logic              f_empty;
    logic              issue_ok;
    logic              req_fire;
    logic              rsp_keep;
    logic              byp;
    logic              f_push;
    logic              f_pop;
    logic [ADDR_W-1:0] rsp_addr;

    always_comb begin
        f_empty  = (f_cnt_q == '0);
        rsp_addr = aq_addr_q[aq_rd_q];

        // credit rule: every accepted request already owns a FIFO slot
        issue_ok = rst_n && !jump_en_i
                 && (os_cnt_q < OS_MAX)
                 && ((int'(f_cnt_q) + int'(os_cnt_q)) < DEPTH);
        req_fire = issue_ok && bus.req_ready_i;

        // a response is kept only when no stale request is ahead of it
        rsp_keep = bus.rsp_valid_i && (drop_cnt_q == '0) && !jump_en_i;

`ifdef IFETCH_BYPASS_EN
        byp = rsp_keep && f_empty;
`else
        byp = 1'b0;
`endif

        f_pop  = !f_empty && !jump_en_i && bus.inst_ready_i;
        f_push = rsp_keep && !(byp && bus.inst_ready_i);

        bus.req_valid_o  = issue_ok;
        bus.req_addr_o   = pc_addr_i;
        pc_hold_o        = !req_fire && !jump_en_i;
        bus.inst_valid_o = byp || (!f_empty && !jump_en_i);

        if (byp) begin
            bus.inst_o      = bus.rsp_data_i;
            bus.inst_addr_o = rsp_addr;
        end else if (f_empty) begin
            bus.inst_o      = '0;
            bus.inst_addr_o = '0;
        end else begin
            bus.inst_o      = f_data_q[f_rd_q];
            bus.inst_addr_o = f_addr_q[f_rd_q];
        end
    end

    always_comb begin
        aq_wr_d = aq_wr_q;
        aq_rd_d = aq_rd_q;
        if (req_fire) begin
            aq_wr_d = (aq_wr_q == AQ_LAST) ? '0 : aq_wr_q + QW'(1);
        end
        if (bus.rsp_valid_i) begin
            aq_rd_d = (aq_rd_q == AQ_LAST) ? '0 : aq_rd_q + QW'(1);
        end

        os_cnt_d = os_cnt_q
                 + {{QW{1'b0}}, req_fire}
                 - {{QW{1'b0}}, bus.rsp_valid_i};

        // on a jump nothing issues, so all remaining requests go stale
        drop_cnt_d = drop_cnt_q;
        if (jump_en_i) begin
            drop_cnt_d = os_cnt_d;
        end else if (bus.rsp_valid_i && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - (QW+1)'(1);
        end

        if (jump_en_i) begin
            f_wr_d  = '0;
            f_rd_d  = '0;
            f_cnt_d = '0;
        end else begin
            f_wr_d  = f_wr_q + {{(PW-1){1'b0}}, f_push};
            f_rd_d  = f_rd_q + {{(PW-1){1'b0}}, f_pop};
            f_cnt_d = f_cnt_q
                    + {{PW{1'b0}}, f_push}
                    - {{PW{1'b0}}, f_pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aq_wr_q    <= '0;
            aq_rd_q    <= '0;
            os_cnt_q   <= '0;
            drop_cnt_q <= '0;
            f_wr_q     <= '0;
            f_rd_q     <= '0;
            f_cnt_q    <= '0;
        end else begin
            aq_wr_q    <= aq_wr_d;
            aq_rd_q    <= aq_rd_d;
            os_cnt_q   <= os_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            f_wr_q     <= f_wr_d;
            f_rd_q     <= f_rd_d;
            f_cnt_q    <= f_cnt_d;
        end
    end

    // storage arrays need no reset: counts gate every read
    always_ff @(posedge clk) begin
        if (req_fire) begin
            aq_addr_q[aq_wr_q] <= pc_addr_i;
        end
        if (f_push) begin
            f_addr_q[f_wr_q] <= rsp_addr;
            f_data_q[f_wr_q] <= bus.rsp_data_i;
        end
    end
endmodule

// File: tb/tb_ifetch_buf.sv
// tb_ifetch_buf: vector table, directed jump/bypass sequences and a
// randomized run against a queue-based reference model of ifetch_buf.
module tb_ifetch_buf;
    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int DEPTH  = 4;
    localparam int MAX_OS = 2;
`ifdef IFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [AW-1:0] addr;
        int            epoch;
        int            due;
    } req_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    typedef struct {
        bit            rr;
        bit            ir;
        bit            rv;
        bit            hold;
        bit            iv;
        logic [AW-1:0] ia;
    } vec_t;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic [AW-1:0] pc_addr = '0;
    logic          jump_en = 1'b0;
    logic          pc_hold;

    ifetch_buf_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ifetch_buf #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .DEPTH (DEPTH),
        .MAX_OS(MAX_OS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pc_addr_i(pc_addr),
        .jump_en_i(jump_en),
        .pc_hold_o(pc_hold),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int            errors   = 0;
    int            checks   = 0;
    int            cyc      = 0;
    int            epoch    = 0;
    int            lat      = 1;
    bit            lat_rand = 1'b0;
    logic [AW-1:0] pc_nxt   = '0;
    logic [AW-1:0] tgt      = '0;
    req_t          mq[$];
    ent_t          eq[$];
    logic [AW-1:0] fired[$];

    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // next cycle: PC register update and in-order memory response
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        pc_addr = pc_nxt;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            bus.rsp_valid_i = 1'b1;
            bus.rsp_data_i  = mem_data(mq[0].addr);
        end else begin
            bus.rsp_valid_i = 1'b0;
            bus.rsp_data_i  = $urandom;
        end
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        jump_en          = 1'b0;
        bus.req_ready_i  = 1'b1;
        bus.inst_ready_i = 1'b1;
        bus.rsp_valid_i  = 1'b0;
        bus.rsp_data_i   = '0;
        mq.delete();
        eq.delete();
        fired.delete();
        pc_nxt   = '0;
        pc_addr  = '0;
        lat      = 1;
        lat_rand = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_valid", bus.req_valid_o, 0);
        chk("rst_inst_valid", bus.inst_valid_o, 0);
        chk("rst_inst", bus.inst_o, 0);
        chk("rst_inst_addr", bus.inst_addr_o, 0);
        chk("rst_pc_hold", pc_hold, 1);
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_inst(output bit found);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(negedge clk);
            if (bus.inst_valid_o) found = 1'b1;
            else step();
        end
    endtask

    // reference model: requests tagged with a jump epoch; a response is
    // delivered only if its epoch is current and no jump is in progress
    always @(negedge clk) begin
        bit   jmp, rsp, live, byp, exp_rv, exp_iv, fire;
        ent_t head;
        req_t r;
        if (rst_n) begin
            jmp    = jump_en;
            rsp    = bus.rsp_valid_i;
            live   = rsp && mq.size() > 0 && mq[0].epoch == epoch;
            byp    = BYP && live && !jmp && eq.size() == 0;
            exp_iv = byp || (eq.size() > 0 && !jmp);
            exp_rv = !jmp && mq.size() < MAX_OS
                   && (eq.size() + mq.size()) < DEPTH;
            fire   = exp_rv && bus.req_ready_i;
            chk("req_valid", bus.req_valid_o, exp_rv);
            chk("pc_hold", pc_hold, !fire && !jmp);
            chk("req_addr", bus.req_addr_o, pc_addr);
            chk("inst_valid", bus.inst_valid_o, exp_iv);
            head = '{'0, '0};
            if (exp_iv) begin
                if (byp) head = '{mq[0].addr, mem_data(mq[0].addr)};
                else     head = eq[0];
                chk("inst_addr", bus.inst_addr_o, head.addr);
                chk("inst_data", bus.inst_o, head.data);
            end
            if (bus.req_valid_o && bus.req_ready_i)
                fired.push_back(bus.req_addr_o);
            if (byp) begin
                if (!bus.inst_ready_i) eq.push_back(head);
            end else begin
                if (exp_iv && bus.inst_ready_i) void'(eq.pop_front());
                if (live && !jmp)
                    eq.push_back('{mq[0].addr, mem_data(mq[0].addr)});
            end
            if (rsp && mq.size() > 0) void'(mq.pop_front());
            if (jmp) begin
                eq.delete();
                epoch++;
            end
            if (fire) begin
                r.addr  = pc_addr;
                r.epoch = epoch;
                r.due   = cyc + (lat_rand ? int'($urandom_range(1, 4)) : lat);
                mq.push_back(r);
            end
            pc_nxt = jmp ? tgt : (pc_hold ? pc_addr : pc_addr + 32'd4);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl[16];
        bit   found;
        bit   hit;

        // fill to the credit limit with decode stalled, then drain
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0, BYP,  32'h0};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0};
        for (int i = 4; i < 10; i++)
            tbl[i] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0};
        tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h4};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h8};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'hC};
        tbl[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h10};
        tbl[15] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h14};

        do_reset();
        for (int i = 0; i < 16; i++) begin
            if (i > 0) step();
            bus.req_ready_i  = tbl[i].rr;
            bus.inst_ready_i = tbl[i].ir;
            @(negedge clk);
            chk($sformatf("tbl%0d_rv", i), bus.req_valid_o, tbl[i].rv);
            chk($sformatf("tbl%0d_hold", i), pc_hold, tbl[i].hold);
            chk($sformatf("tbl%0d_iv", i), bus.inst_valid_o, tbl[i].iv);
            if (tbl[i].iv)
                chk($sformatf("tbl%0d_ia", i), bus.inst_addr_o, tbl[i].ia);
        end

        // jump with 0x10 and 0x14 outstanding, latency 3
        do_reset();
        lat = 3;
        bus.req_ready_i = 1'b0;
        jump_en = 1'b1;
        tgt = 32'h10;
        step();
        jump_en = 1'b0;
        bus.req_ready_i = 1'b1;
        step();
        step();
        jump_en = 1'b1;
        tgt = 32'h100;
        step();
        jump_en = 1'b0;
        wait_inst(found);
        chk("jmpA_found", found, 1);
        chk("jmpA_addr", bus.inst_addr_o, 32'h100);
        chk("jmpA_data", bus.inst_o, mem_data(32'h100));

        // jump in the same cycle as the response for 0x20
        do_reset();
        lat = 2;
        bus.req_ready_i = 1'b0;
        jump_en = 1'b1;
        tgt = 32'h20;
        step();
        jump_en = 1'b0;
        bus.req_ready_i = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            step();
            hit = bus.rsp_valid_i && mq.size() == 2 && mq[0].addr == 32'h20;
        end
        chk("jmpB_sync", hit, 1);
        jump_en = 1'b1;
        tgt = 32'h200;
        step();
        jump_en = 1'b0;
        wait_inst(found);
        chk("jmpB_found", found, 1);
        chk("jmpB_addr", bus.inst_addr_o, 32'h200);

        // request ready toggling: every address exactly once, in order
        do_reset();
        for (int i = 0; i < 24; i++) begin
            bus.req_ready_i = (i % 2 == 0);
            step();
        end
        chk("toggle_count_ge8", fired.size() >= 8, 1);
        for (int i = 0; i < fired.size(); i++)
            chk($sformatf("toggle_addr%0d", i), fired[i], 32'(i * 4));

        // response to empty FIFO: same-cycle with bypass, else next cycle
        do_reset();
        step();
        bus.req_ready_i = 1'b0;
        @(negedge clk);
        chk("byp_rsp_seen", bus.rsp_valid_i, 1);
        chk("byp_same_cycle", bus.inst_valid_o, BYP);
        step();
        @(negedge clk);
        chk("byp_next_cycle", bus.inst_valid_o, !BYP);

        // randomized traffic, latency 1..4, random jumps, one mid-run reset
        do_reset();
        lat_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                do_reset();
                lat_rand = 1'b1;
            end else begin
                step();
            end
            bus.req_ready_i  = ($urandom_range(0, 3) != 0);
            bus.inst_ready_i = ($urandom_range(0, 2) != 0);
            jump_en          = ($urandom_range(0, 19) == 0);
            tgt              = $urandom & 32'h0000_FFFC;
        end
        step();
        jump_en = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ifetch_buf.md
Name: ifetch_buf

Overview:
- Instruction-fetch front end. Consumes the PC register's address stream and issues in-order read requests to instruction memory over a valid/ready request channel plus a valid-only response channel.
- Buffers returned instructions, each tagged with its address, in a FIFO for the decode stage.
- Discards stale fetches on a jump and drives a hold request back to the PC register so no address is skipped.

Parameters:
- ADDR_W, 32, instruction address width.
- DATA_W, 32, instruction width.
- DEPTH, 4, instruction FIFO entries; power of two, ≥2.
- MAX_OS, 2, maximum outstanding memory requests; power of two, ≥1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- pc_addr_i  in  ADDR_W  current PC value
- jump_en_i  in  1  jump/flush, active-high
- pc_hold_o  out  1  1 = PC register must hold its value this cycle
- req_valid_o  out  1  memory read request valid
- req_addr_o  out  ADDR_W  request address (= pc_addr_i)
- req_ready_i  in  1  memory accepts request
- rsp_valid_i  in  1  read data valid; responses return in request order, latency ≥1 cycle
- rsp_data_i  in  DATA_W  read data
- inst_valid_o  out  1  instruction available to decode
- inst_o  out  DATA_W  instruction
- inst_addr_o  out  ADDR_W  address of inst_o
- inst_ready_i  in  1  decode consumes instruction

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empty; outstanding count os_cnt=0; drop_cnt=0; address queue empty.
  - Outputs: req_valid_o=0, inst_valid_o=0, inst_o=0, inst_addr_o=0, pc_hold_o=1.
  - Reset mid-transaction drops all in-flight state. Responses arriving after reset release are not expected; the memory is reset together with this block.
- Issue:
  - Condition: req_valid_o = !jump_en_i && os_cnt<MAX_OS && (fifo_cnt + os_cnt) < DEPTH.
  - The credit rule guarantees every accepted request has a FIFO slot, so the FIFO never overflows.
  - On handshake (req_valid_o && req_ready_i):
    - pc_addr_i is pushed into the MAX_OS-entry address queue;
    - os_cnt increments.
- PC hold:
  - pc_hold_o = !(req_valid_o && req_ready_i) && !jump_en_i.
  - The PC advances only on an accepted request or on a jump.
- Response, with drop_cnt=0:
  - Pop the address queue.
  - Push {addr, rsp_data_i} into the FIFO; os_cnt decrements.
  - A same-cycle issue and response leaves os_cnt unchanged.
- Response, with drop_cnt>0:
  - Pop the address queue and discard the data.
  - drop_cnt and os_cnt decrement.
- Output:
  - inst_valid_o = FIFO not empty && !jump_en_i.
  - inst_o and inst_addr_o come from the FIFO head.
  - Pop when inst_valid_o && inst_ready_i.
  - Minimum latency is 1 cycle from the response edge to inst_valid_o (without bypass).
- Flush (jump_en_i=1 at an edge):
  - FIFO cleared.
  - drop_cnt <= os_cnt − (rsp_valid_i && drop_cnt==0 ? 1 : 0) + drop_cnt adjustment. Net effect: every request still in flight after this edge is discarded.
  - A response arriving in the jump cycle is discarded.
  - No request is issued in the jump cycle.
  - The next cycle fetches from the new pc_addr_i (the jump target).
- Simultaneous events:
  - Push and pop in the same cycle keep fifo_cnt unchanged.
  - Full FIFO with response: unreachable by the credit rule.
  - Jump while drop_cnt>0 accumulates correctly; drop_cnt never exceeds MAX_OS.
- Pointer and count arithmetic:
  - Pointers wrap modulo DEPTH and MAX_OS.
  - Counts are one bit wider than the pointers.

Optional Feature:
- Macro: IFETCH_BYPASS_EN.
- Defined:
  - When the FIFO is empty, drop_cnt=0 and rsp_valid_i=1, the response drives inst_valid_o/inst_o/inst_addr_o combinationally in the same cycle.
  - If inst_ready_i=1, the entry is not written to the FIFO; otherwise it is pushed normally.
  - Bypass is suppressed while jump_en_i=1.
- Undefined: all responses pass through the FIFO with 1-cycle minimum latency.

Test Plan:
- Reset release, req_ready_i=1, memory latency 1, inst_ready_i=1, PC from 0x0 → requests at 0x0, 0x4, 0x8…; inst_addr_o follows the same sequence 2 cycles behind its request; pc_hold_o=0 in steady state.
- inst_ready_i=0 for 10 cycles → exactly 4 instructions buffered (fifo_cnt+os_cnt=DEPTH); req_valid_o=0; pc_hold_o=1; PC frozen. Release → 0x0,0x4,0x8,0xC delivered in order, none lost.
- Latency 3, two requests outstanding (0x10, 0x14), jump_en_i with target 0x100 → both responses discarded; next inst_addr_o=0x100 with data from that address.
- Jump coincident with a response for 0x20 and one further request in flight → both discarded; drop_cnt returns to 0; no stale instruction appears.
- req_ready_i toggling 1/0 every cycle → each address is requested exactly once, with no gaps or duplicates; PC advances only on handshakes.
- IFETCH_BYPASS_EN defined, empty FIFO, inst_ready_i=1 → inst_valid_o asserts in the same cycle as rsp_valid_i and the FIFO stays empty. Undefined → inst_valid_o asserts one cycle later.
